// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg_disp_pkg;

   localparam int unsigned SEG_W      = 7;
   localparam int unsigned MAX_DIGITS = 16;
   localparam int unsigned IDX_W      = 4;

   localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;
   localparam logic [MAX_DIGITS-1:0] ANO_OFF = '1;

   localparam logic [SEG_W-1:0] SEG_0    = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1    = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2    = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3    = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4    = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5    = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6    = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7    = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8    = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9    = 7'h10;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'h3F;

   // Active-low one-hot anode pattern; indices at or beyond n leave every anode off.
   function automatic logic [MAX_DIGITS-1:0] digit_onehot_n(input logic [IDX_W-1:0] idx,
                                                            input int unsigned       n);
      logic [MAX_DIGITS-1:0] r;
      r = ANO_OFF;
      if (32'(idx) < n) r[idx] = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/scan_timebase.sv
// Slot counter, digit index, frame pulse and blink phase for the display scanner.
module scan_timebase #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned DIV_W      = 18,
   parameter int unsigned BLINK_W    = 4,
   parameter int unsigned DIG_W      = $clog2(NUM_DIGITS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [DIV_W-1:0] cnt,
   output logic [DIG_W-1:0] digit,
   output logic [DIG_W-1:0] digit_nxt_c,
   output logic             tick_c,
   output logic             frame_done,
   output logic             blink_ph
);

   logic               last_digit_c;
   logic               frame_end_c;
   logic [BLINK_W-1:0] frame_cnt;

   assign tick_c       = en & (&cnt);
   assign last_digit_c = (digit == DIG_W'(NUM_DIGITS - 1));
   assign frame_end_c  = tick_c & last_digit_c;

   always_comb begin
      digit_nxt_c = digit;
      if (tick_c) digit_nxt_c = last_digit_c ? '0 : digit + DIG_W'(1);
   end

   // Everything holds while en is low, so en edges can never fake a frame end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         digit      <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         blink_ph   <= 1'b0;
      end else begin
         if (en) cnt <= cnt + DIV_W'(1);
         digit      <= digit_nxt_c;
         frame_done <= frame_end_c;
         if (frame_end_c) begin
            frame_cnt <= frame_cnt + BLINK_W'(1);
            if (&frame_cnt) blink_ph <= ~blink_ph;
         end
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with PWM brightness, blank and blink.
// Per-digit inputs are snapshotted at slot start so mid-slot changes never tear.
module seg_scan_driver
   import seg_disp_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned DIV_W      = 18,
   parameter int unsigned BRIGHT_W   = 3,
   parameter int unsigned BLINK_W    = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
   input  logic [NUM_DIGITS-1:0]       dot_in,
   input  logic [NUM_DIGITS-1:0]       blank,
   input  logic [NUM_DIGITS-1:0]       blink,
   input  logic [BRIGHT_W-1:0]         brightness,
   output logic [SEG_W-1:0]            seg,
   output logic                        dp,
   output logic [NUM_DIGITS-1:0]       ano,
   output logic                        frame_done
);

   localparam int unsigned DIG_W = $clog2(NUM_DIGITS);

   logic [DIV_W-1:0]      cnt;
   logic [DIG_W-1:0]      digit;
   logic [DIG_W-1:0]      digit_nxt_c;
   logic                  tick_c;
   logic                  blink_ph;

   logic                  first_q;
   logic [SEG_W-1:0]      seg_s;
   logic                  dot_s, blank_s, blink_s;
   logic [SEG_W-1:0]      seg_live_c, cur_seg_c;
   logic                  dot_live_c, blank_live_c, blink_live_c;
   logic                  cur_dot_c, cur_blank_c, cur_blink_c;
   logic [BRIGHT_W-1:0]   phase_c;
   logic                  lit_c;
   logic [NUM_DIGITS-1:0] ano_on_c;

   scan_timebase #(
      .NUM_DIGITS (NUM_DIGITS),
      .DIV_W      (DIV_W),
      .BLINK_W    (BLINK_W),
      .DIG_W      (DIG_W)
   ) u_timebase (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .cnt         (cnt),
      .digit       (digit),
      .digit_nxt_c (digit_nxt_c),
      .tick_c      (tick_c),
      .frame_done  (frame_done),
      .blink_ph    (blink_ph)
   );

   // Live inputs of the digit that owns the upcoming slot.
   always_comb begin
      seg_live_c   = SEG_OFF;
      dot_live_c   = 1'b1;
      blank_live_c = 1'b1;
      blink_live_c = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (digit_nxt_c == DIG_W'(i)) begin
            seg_live_c   = seg_in[SEG_W*i +: SEG_W];
            dot_live_c   = dot_in[i];
            blank_live_c = blank[i];
            blink_live_c = blink[i];
         end
      end
   end

   // first_q marks the cycle after reset release, before digit 0 has been captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q <= 1'b1;
         seg_s   <= SEG_OFF;
         dot_s   <= 1'b1;
         blank_s <= 1'b1;
         blink_s <= 1'b0;
      end else begin
         first_q <= 1'b0;
         if (tick_c | first_q) begin
            seg_s   <= seg_live_c;
            dot_s   <= dot_live_c;
            blank_s <= blank_live_c;
            blink_s <= blink_live_c;
         end
      end
   end

   assign cur_seg_c   = first_q ? seg_live_c   : seg_s;
   assign cur_dot_c   = first_q ? dot_live_c   : dot_s;
   assign cur_blank_c = first_q ? blank_live_c : blank_s;
   assign cur_blink_c = first_q ? blink_live_c : blink_s;

   // Last clock of each slot is always dark: break-before-make between digits.
   assign phase_c  = cnt[DIV_W-1 -: BRIGHT_W];
   assign lit_c    = en & ~cur_blank_c & ~(cur_blink_c & blink_ph)
                   & (phase_c <= brightness) & ~(&cnt);
   assign ano_on_c = NUM_DIGITS'(digit_onehot_n(IDX_W'(digit), NUM_DIGITS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ano <= NUM_DIGITS'(ANO_OFF);
         seg <= SEG_OFF;
         dp  <= 1'b1;
      end else if (lit_c) begin
         ano <= ano_on_c;
         seg <= cur_seg_c;
         dp  <= cur_dot_c;
      end else begin
         ano <= NUM_DIGITS'(ANO_OFF);
         seg <= SEG_OFF;
         dp  <= 1'b1;
      end
   end

endmodule
